// File: rtl/stage_sequencer_if.sv
// Bundle of the pipeline-control signals exchanged between the pipeline
// datapath (master) and the stage sequencer (slave).
interface stage_sequencer_if;
   logic        start;
   logic        ex_valid;
   logic [15:0] ex_opcode;
   logic        branch_taken;
   logic        fetch_en;
   logic        decode_en;
   logic        execute_en;
   logic        wb_en;
   logic        pc_load;
   logic        nop_insert;
   logic        halted;
   logic        err_illegal;
   logic [2:0]  state;
   logic [15:0] retired_count;

   // Datapath side: drives the execute-stage information, observes the enables.
   modport master (
      output start, ex_valid, ex_opcode, branch_taken,
      input  fetch_en, decode_en, execute_en, wb_en, pc_load, nop_insert,
      input  halted, err_illegal, state, retired_count
   );

   // Sequencer side: consumes the execute-stage information, produces the enables.
   modport slave (
      input  start, ex_valid, ex_opcode, branch_taken,
      output fetch_en, decode_en, execute_en, wb_en, pc_load, nop_insert,
      output halted, err_illegal, state, retired_count
   );
endinterface

// File: rtl/stage_sequencer.sv
// Stage sequencer: Moore FSM that generates per-stage advance enables for a
// four-stage pipeline, stalling for multi-cycle MULs, flushing after taken
// branches, stopping on HLT and counting retired instructions.
module stage_sequencer #(
   parameter int MUL_LATENCY  = 3,
   parameter int FLUSH_CYCLES = 2
) (
   input logic              clock,
   input logic              reset,
   stage_sequencer_if.slave bus
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_RUN      = 3'd1;
   localparam logic [2:0] ST_MUL_WAIT = 3'd2;
   localparam logic [2:0] ST_FLUSH    = 3'd3;
   localparam logic [2:0] ST_HALT     = 3'd4;

   localparam logic [15:0] OP_BR  = 16'h0100;
   localparam logic [15:0] OP_BNE = 16'h0200;
   localparam logic [15:0] OP_MUL = 16'h1000;
   localparam logic [15:0] OP_HLT = 16'h2000;
   localparam logic [15:0] OP_NOP = 16'h4000;

   localparam logic [3:0] STALL_LOAD = 4'(MUL_LATENCY);
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

   logic [2:0]  state_q;
   logic [2:0]  state_d;
   logic [3:0]  stall_cnt;
   logic [3:0]  stall_d;
   logic [2:0]  flush_cnt;
   logic [2:0]  flush_d;
   logic        retire;
   logic        flag_illegal;
   logic        op_one_hot;

   logic        fetch_en_q;
   logic        decode_en_q;
   logic        execute_en_q;
   logic        wb_en_q;
   logic        pc_load_q;
   logic        nop_insert_q;
   logic        halted_q;
   logic        err_illegal_q;
   logic [15:0] retired_count_q;

   // Legal opcodes have exactly one bit set; x & (x-1) clears the lowest set bit.
   always_comb begin
      op_one_hot = (bus.ex_opcode != 16'd0) &&
                   ((bus.ex_opcode & (bus.ex_opcode - 16'd1)) == 16'd0);
   end

   // Next-state, counter and retirement decisions for the current cycle.
   always_comb begin
      state_d      = state_q;
      stall_d      = stall_cnt;
      flush_d      = flush_cnt;
      retire       = 1'b0;
      flag_illegal = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.ex_valid) begin
               if (!op_one_hot) begin
                  flag_illegal = 1'b1;
               end else if (bus.ex_opcode == OP_MUL) begin
                  state_d = ST_MUL_WAIT;
                  stall_d = STALL_LOAD;
               end else if (bus.ex_opcode == OP_HLT) begin
                  state_d = ST_HALT;
                  retire  = 1'b1;
               end else if ((bus.ex_opcode == OP_BR) ||
                            ((bus.ex_opcode == OP_BNE) && bus.branch_taken)) begin
                  state_d = ST_FLUSH;
                  flush_d = FLUSH_LOAD;
                  retire  = 1'b1;
               end else if (bus.ex_opcode != OP_NOP) begin
                  retire = 1'b1;
               end
            end
         end
         ST_MUL_WAIT: begin
            stall_d = stall_cnt - 4'd1;
            if (stall_cnt <= 4'd1) begin
               state_d = ST_RUN;
               stall_d = 4'd0;
               retire  = 1'b1;
            end
         end
         ST_FLUSH: begin
            flush_d = flush_cnt - 3'd1;
            if (flush_cnt <= 3'd1) begin
               state_d = ST_RUN;
               flush_d = 3'd0;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
            stall_d = 4'd0;
            flush_d = 3'd0;
         end
      endcase
   end

   // State, counters and all outputs are registered from the next-state view.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         stall_cnt       <= 4'd0;
         flush_cnt       <= 3'd0;
         fetch_en_q      <= 1'b0;
         decode_en_q     <= 1'b0;
         execute_en_q    <= 1'b0;
         wb_en_q         <= 1'b0;
         pc_load_q       <= 1'b0;
         nop_insert_q    <= 1'b0;
         halted_q        <= 1'b0;
         err_illegal_q   <= 1'b0;
         retired_count_q <= 16'd0;
      end else begin
         state_q         <= state_d;
         stall_cnt       <= stall_d;
         flush_cnt       <= flush_d;
         fetch_en_q      <= (state_d == ST_RUN) || (state_d == ST_FLUSH);
         decode_en_q     <= (state_d == ST_RUN) || (state_d == ST_FLUSH);
         execute_en_q    <= (state_d == ST_RUN) || (state_d == ST_FLUSH);
         wb_en_q         <= (state_d == ST_RUN) ||
                            ((state_d == ST_MUL_WAIT) && (stall_d == 4'd1));
         pc_load_q       <= (state_q == ST_RUN) && (state_d == ST_FLUSH);
         nop_insert_q    <= (state_d == ST_FLUSH);
         halted_q        <= (state_d == ST_HALT);
         err_illegal_q   <= err_illegal_q | flag_illegal;
         retired_count_q <= retired_count_q + {15'd0, retire};
      end
   end

   assign bus.state         = state_q;
   assign bus.fetch_en      = fetch_en_q;
   assign bus.decode_en     = decode_en_q;
   assign bus.execute_en    = execute_en_q;
   assign bus.wb_en         = wb_en_q;
   assign bus.pc_load       = pc_load_q;
   assign bus.nop_insert    = nop_insert_q;
   assign bus.halted        = halted_q;
   assign bus.err_illegal   = err_illegal_q;
   assign bus.retired_count = retired_count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed testbench for stage_sequencer with hand-computed expectations.
module tb_stage_sequencer;

   logic clock;
   logic reset;
   int   checks;
   int   failures;
   logic [7:0] outs;

   stage_sequencer_if bus ();

   stage_sequencer #(.MUL_LATENCY(3), .FLUSH_CYCLES(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Packed view: fetch, decode, execute, wb, pc_load, nop_insert, halted, err_illegal.
   assign outs = {bus.fetch_en, bus.decode_en, bus.execute_en, bus.wb_en,
                  bus.pc_load, bus.nop_insert, bus.halted, bus.err_illegal};

   // Free-running 10 ns clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_stimulus(input logic st, input logic vld,
                                 input logic [15:0] op, input logic bt);
      bus.start        = st;
      bus.ex_valid     = vld;
      bus.ex_opcode    = op;
      bus.branch_taken = bt;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      apply_stimulus(1'b1, 1'b1, 16'h0001, 1'b0);
      tick();
      tick();
      checks++;
      if (bus.state !== 3'd0) begin failures++; $display("[TB] FAIL reset_state: got %0d expected 0", bus.state); end
      checks++;
      if (outs !== 8'b0000_0000) begin failures++; $display("[TB] FAIL reset_outs: got %b expected 00000000", outs); end
      checks++;
      if (bus.retired_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.retired_count); end
      apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      reset = 1'b0;
      tick();
      checks++;
      if (bus.state !== 3'd0) begin failures++; $display("[TB] FAIL idle_hold: got %0d expected 0", bus.state); end
   endtask

   task automatic test_add();
      apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      tick();
      checks++;
      if (bus.state !== 3'd1 || outs !== 8'b1111_0000) begin failures++; $display("[TB] FAIL start_run: got state %0d outs %b expected 1 11110000", bus.state, outs); end
      apply_stimulus(1'b0, 1'b1, 16'h0001, 1'b0);
      tick();
      checks++;
      if (bus.state !== 3'd1 || bus.retired_count !== 16'd1) begin failures++; $display("[TB] FAIL add_retire: got state %0d count %0d expected 1 1", bus.state, bus.retired_count); end
      apply_stimulus(1'b0, 1'b0, 16'h0001, 1'b0);
      tick();
      checks++;
      if (bus.state !== 3'd1 || bus.retired_count !== 16'd1) begin failures++; $display("[TB] FAIL invalid_hold: got state %0d count %0d expected 1 1", bus.state, bus.retired_count); end
   endtask

   task automatic test_mul();
      apply_stimulus(1'b0, 1'b1, 16'h1000, 1'b0);
      tick();
      checks++;
      if (bus.state !== 3'd2 || outs !== 8'b0000_0000 || bus.retired_count !== 16'd1) begin failures++; $display("[TB] FAIL mul_cycle1: got state %0d outs %b count %0d expected 2 00000000 1", bus.state, outs, bus.retired_count); end
      apply_stimulus(1'b1, 1'b1, 16'h2000, 1'b0);
      tick();
      checks++;
      if (bus.state !== 3'd2 || outs !== 8'b0000_0000) begin failures++; $display("[TB] FAIL mul_cycle2: got state %0d outs %b expected 2 00000000", bus.state, outs); end
      tick();
      checks++;
      if (bus.state !== 3'd2 || outs !== 8'b0001_0000 || bus.retired_count !== 16'd1) begin failures++; $display("[TB] FAIL mul_cycle3: got state %0d outs %b count %0d expected 2 00010000 1", bus.state, outs, bus.retired_count); end
      apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      tick();
      checks++;
      if (bus.state !== 3'd1 || outs !== 8'b1111_0000 || bus.retired_count !== 16'd2) begin failures++; $display("[TB] FAIL mul_exit: got state %0d outs %b count %0d expected 1 11110000 2", bus.state, outs, bus.retired_count); end
   endtask

   task automatic test_branch();
      apply_stimulus(1'b0, 1'b1, 16'h0200, 1'b0);
      tick();
      checks++;
      if (bus.state !== 3'd1 || outs !== 8'b1111_0000 || bus.retired_count !== 16'd3) begin failures++; $display("[TB] FAIL bne_not_taken: got state %0d outs %b count %0d expected 1 11110000 3", bus.state, outs, bus.retired_count); end
      apply_stimulus(1'b0, 1'b1, 16'h0200, 1'b1);
      tick();
      checks++;
      if (bus.state !== 3'd3 || outs !== 8'b1110_1100 || bus.retired_count !== 16'd4) begin failures++; $display("[TB] FAIL bne_flush1: got state %0d outs %b count %0d expected 3 11101100 4", bus.state, outs, bus.retired_count); end
      tick();
      checks++;
      if (bus.state !== 3'd3 || outs !== 8'b1110_0100) begin failures++; $display("[TB] FAIL bne_flush2: got state %0d outs %b expected 3 11100100", bus.state, outs); end
      apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      tick();
      checks++;
      if (bus.state !== 3'd1 || outs !== 8'b1111_0000 || bus.retired_count !== 16'd4) begin failures++; $display("[TB] FAIL bne_return: got state %0d outs %b count %0d expected 1 11110000 4", bus.state, outs, bus.retired_count); end
      apply_stimulus(1'b0, 1'b1, 16'h0100, 1'b0);
      tick();
      apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checks++;
      if (bus.state !== 3'd3 || outs !== 8'b1110_1100 || bus.retired_count !== 16'd5) begin failures++; $display("[TB] FAIL br_flush1: got state %0d outs %b count %0d expected 3 11101100 5", bus.state, outs, bus.retired_count); end
      tick();
      tick();
      checks++;
      if (bus.state !== 3'd1) begin failures++; $display("[TB] FAIL br_return: got %0d expected 1", bus.state); end
   endtask

   task automatic test_illegal();
      apply_stimulus(1'b0, 1'b1, 16'h0003, 1'b0);
      tick();
      checks++;
      if (bus.state !== 3'd1 || outs !== 8'b1111_0001 || bus.retired_count !== 16'd5) begin failures++; $display("[TB] FAIL illegal_multi: got state %0d outs %b count %0d expected 1 11110001 5", bus.state, outs, bus.retired_count); end
      apply_stimulus(1'b0, 1'b1, 16'h0000, 1'b0);
      tick();
      checks++;
      if (bus.state !== 3'd1 || bus.retired_count !== 16'd5 || bus.err_illegal !== 1'b1) begin failures++; $display("[TB] FAIL illegal_zero: got state %0d count %0d err %b expected 1 5 1", bus.state, bus.retired_count, bus.err_illegal); end
      apply_stimulus(1'b0, 1'b1, 16'h0001, 1'b0);
      tick();
      checks++;
      if (bus.retired_count !== 16'd6 || bus.err_illegal !== 1'b1) begin failures++; $display("[TB] FAIL illegal_sticky: got count %0d err %b expected 6 1", bus.retired_count, bus.err_illegal); end
      apply_stimulus(1'b0, 1'b1, 16'h4000, 1'b0);
      tick();
      checks++;
      if (bus.state !== 3'd1 || bus.retired_count !== 16'd6) begin failures++; $display("[TB] FAIL nop_no_count: got state %0d count %0d expected 1 6", bus.state, bus.retired_count); end
   endtask

   task automatic test_halt();
      apply_stimulus(1'b0, 1'b1, 16'h2000, 1'b0);
      tick();
      checks++;
      if (bus.state !== 3'd4 || outs !== 8'b0000_0011 || bus.retired_count !== 16'd7) begin failures++; $display("[TB] FAIL halt_enter: got state %0d outs %b count %0d expected 4 00000011 7", bus.state, outs, bus.retired_count); end
      apply_stimulus(1'b1, 1'b1, 16'h0001, 1'b0);
      tick();
      apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      tick();
      checks++;
      if (bus.state !== 3'd4 || outs !== 8'b0000_0011 || bus.retired_count !== 16'd7) begin failures++; $display("[TB] FAIL halt_ignore_start: got state %0d outs %b count %0d expected 4 00000011 7", bus.state, outs, bus.retired_count); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (bus.state !== 3'd0 || outs !== 8'b0000_0000 || bus.retired_count !== 16'd0) begin failures++; $display("[TB] FAIL halt_reset: got state %0d outs %b count %0d expected 0 00000000 0", bus.state, outs, bus.retired_count); end
   endtask

   task automatic test_back_to_back();
      apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      tick();
      apply_stimulus(1'b0, 1'b1, 16'h0001, 1'b0);
      tick();
      apply_stimulus(1'b0, 1'b1, 16'h1000, 1'b0);
      tick();
      apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checks++;
      if (bus.state !== 3'd2 || bus.retired_count !== 16'd1) begin failures++; $display("[TB] FAIL b2b_mul: got state %0d count %0d expected 2 1", bus.state, bus.retired_count); end
      tick();
      tick();
      tick();
      checks++;
      if (bus.state !== 3'd1 || bus.retired_count !== 16'd2) begin failures++; $display("[TB] FAIL b2b_return: got state %0d count %0d expected 1 2", bus.state, bus.retired_count); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_wrap_and_mul_reset();
      apply_stimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      tick();
      apply_stimulus(1'b0, 1'b1, 16'h0001, 1'b0);
      for (int i = 0; i < 65535; i++) begin
         tick();
      end
      checks++;
      if (bus.retired_count !== 16'hFFFF) begin failures++; $display("[TB] FAIL count_preload: got %h expected ffff", bus.retired_count); end
      tick();
      checks++;
      if (bus.retired_count !== 16'h0000 || bus.state !== 3'd1) begin failures++; $display("[TB] FAIL count_wrap: got count %h state %0d expected 0000 1", bus.retired_count, bus.state); end
      apply_stimulus(1'b0, 1'b1, 16'h1000, 1'b0);
      tick();
      apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      tick();
      checks++;
      if (bus.state !== 3'd2) begin failures++; $display("[TB] FAIL mul_second_cycle: got %0d expected 2", bus.state); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (bus.state !== 3'd0 || outs !== 8'b0000_0000 || bus.retired_count !== 16'd0) begin failures++; $display("[TB] FAIL mul_reset: got state %0d outs %b count %0d expected 0 00000000 0", bus.state, outs, bus.retired_count); end
      tick();
      checks++;
      if (bus.state !== 3'd0 || outs !== 8'b0000_0000) begin failures++; $display("[TB] FAIL mul_reset_hold: got state %0d outs %b expected 0 00000000", bus.state, outs); end
   endtask

   // Scenario sequence followed by the summary line.
   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      test_reset();
      test_add();
      test_mul();
      test_branch();
      test_illegal();
      test_halt();
      test_back_to_back();
      test_wrap_and_mul_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
